// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// default geometry of the instruction memory it addresses.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_DEPTH_DEF = 256;
    localparam int RESET_PC      = 0;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_if.sv
// Bundle of control, instruction-memory, redirect and decoder-side signals
// around the fetch stage; master is the fetch unit, slave its environment.
interface instruction_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();

    logic              start;
    logic              halt;
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] read_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              fault;
    logic [15:0]       fetch_count;

    modport master (
        input  start, halt, read_data, redirect_valid, redirect_pc, out_ready,
        output inst_address, out_valid, out_inst, out_pc, fault, fetch_count
    );

    modport slave (
        output start, halt, read_data, redirect_valid, redirect_pc, out_ready,
        input  inst_address, out_valid, out_inst, out_pc, fault, fetch_count
    );

endinterface : instruction_fetch_if

// File: rtl/instruction_fetch_fetch_out_reg.sv
// Output holding register of the fetch stage: captures an instruction and its
// address on load, holds while stalled, and drops the valid bit on flush.
module fetch_out_reg #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q;
    logic [DATA_W-1:0] inst_q;
    logic [ADDR_W-1:0] pc_q;

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule : fetch_out_reg

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks a wrapping PC through instruction memory and
// hands words to the decoder through a valid/ready register, with redirects.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    instruction_fetch_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [15:0]       count_q, count_d;

    logic              valid_w;
    logic [DATA_W-1:0] inst_w;
    logic [ADDR_W-1:0] out_pc_w;
    logic              handshake, redirect_ok, redirect_bad;
    logic              fetch_en, load, flush;

    assign handshake    = valid_w && bus.out_ready;
    assign redirect_ok  = bus.redirect_valid && (32'(bus.redirect_pc) < 32'(MEM_DEPTH));
    assign redirect_bad = bus.redirect_valid && !redirect_ok;

    // Halt blocks new loads so the stage drains the held word and then stops.
    assign fetch_en = (state_q == ST_RUN) && (!valid_w || bus.out_ready) && !bus.halt;
    assign load     = fetch_en && !bus.redirect_valid;
    assign flush    = bus.redirect_valid || (handshake && !fetch_en);

    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;

        if (handshake && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;

        if (redirect_bad) begin
            fault_d = 1'b1;
            state_d = ST_HALTED;
        end else begin
            case (state_q)
                ST_IDLE:   if (bus.start) state_d = bus.halt ? ST_HALTED : ST_RUN;
                ST_RUN:    if (bus.halt && (!valid_w || handshake)) state_d = ST_HALTED;
                ST_HALTED: if (bus.start && !bus.halt) state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase

            if (redirect_ok && state_q != ST_IDLE)
                pc_d = bus.redirect_pc;
            else if (load)
                pc_d = (pc_q == LAST_PC) ? PC_RST : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RST;
            fault_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    fetch_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .flush_i (flush),
        .inst_i  (bus.read_data),
        .pc_i    (pc_q),
        .valid_o (valid_w),
        .inst_o  (inst_w),
        .pc_o    (out_pc_w)
    );

    assign bus.inst_address = pc_q;
    assign bus.out_valid    = valid_w;
    assign bus.out_inst     = inst_w;
    assign bus.out_pc       = out_pc_w;
    assign bus.fault        = fault_q;
    assign bus.fetch_count  = count_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for the fetch stage: a combinational memory model feeds the
// DUT and each step compares outputs against hand-derived values.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    instruction_fetch #(
        .ADDR_W    (16),
        .DATA_W    (32),
        .MEM_DEPTH (256)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input int a);
        return (a == 0) ? 32'h2000_0004 : (32'hC0DE_0000 | 32'(a));
    endfunction

    assign bus.read_data = mem_word(int'(bus.inst_address));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] pc);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".pc"},    64'(bus.out_pc),    64'(pc));
        check({tag, ".inst"},  64'(bus.out_inst),  64'(mem_word(int'(pc))));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(bus.out_valid),    64'd0);
        check({tag, ".pc"},    64'(bus.out_pc),       64'd0);
        check({tag, ".inst"},  64'(bus.out_inst),     64'd0);
        check({tag, ".fault"}, 64'(bus.fault),        64'd0);
        check({tag, ".count"}, 64'(bus.fetch_count),  64'd0);
        check({tag, ".addr"},  64'(bus.inst_address), 64'd0);
        check({tag, ".state"}, 64'(dut.state_q),      64'(ST_IDLE));
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.start          = 1'b0;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        #3;
        check_zero("reset");
        tick(); tick();
        rst_n = 1'b1;

        // No fetching before start.
        tick(); tick(); tick();
        check("idle.valid", 64'(bus.out_valid), 64'd0);
        check("idle.addr",  64'(bus.inst_address), 64'd0);

        // Start: RUN after first edge, first word after second edge.
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start.state", 64'(dut.state_q), 64'(ST_RUN));
        check("start.valid", 64'(bus.out_valid), 64'd0);
        tick();
        check_out("first", 16'd0);
        check("first.addr", 64'(bus.inst_address), 64'd1);
        tick();
        check_out("seq1", 16'd1);
        tick();
        check_out("seq2", 16'd2);
        check("seq2.count", 64'(bus.fetch_count), 64'd2);

        // Stall three cycles at out_pc=2.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("stall", 16'd2);
            check("stall.addr",  64'(bus.inst_address), 64'd3);
            check("stall.count", 64'(bus.fetch_count),  64'd2);
        end
        bus.out_ready = 1'b1;
        tick();
        check_out("release", 16'd3);
        check("release.count", 64'(bus.fetch_count), 64'd3);

        // Redirect to 5 while out_pc=3, handshake in the same cycle.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0005;
        tick();
        bus.redirect_valid = 1'b0;
        check("redir.valid", 64'(bus.out_valid),    64'd0);
        check("redir.addr",  64'(bus.inst_address), 64'd5);
        check("redir.count", 64'(bus.fetch_count),  64'd4);
        tick();
        check_out("redir.tgt", 16'd5);
        tick();
        check_out("redir.next", 16'd6);
        check("redir.next.count", 64'(bus.fetch_count), 64'd5);

        // Wrap from 255 to 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'd254;
        tick();
        bus.redirect_valid = 1'b0;
        check("wrap.flush", 64'(bus.out_valid), 64'd0);
        tick();
        check_out("wrap.254", 16'd254);
        tick();
        check_out("wrap.255", 16'd255);
        tick();
        check_out("wrap.0", 16'd0);
        check("wrap.addr",  64'(bus.inst_address), 64'd1);
        check("wrap.count", 64'(bus.fetch_count),  64'd8);

        // Halt: held word accepted, then HALTED with pc held.
        bus.halt = 1'b1;
        tick();
        check("halt.state", 64'(dut.state_q),      64'(ST_HALTED));
        check("halt.valid", 64'(bus.out_valid),    64'd0);
        check("halt.addr",  64'(bus.inst_address), 64'd1);
        check("halt.count", 64'(bus.fetch_count),  64'd9);
        tick();
        bus.halt = 1'b0;
        tick();
        check("halted.addr", 64'(bus.inst_address), 64'd1);

        // start with halt: halt wins.
        bus.start = 1'b1;
        bus.halt  = 1'b1;
        tick();
        check("both.state", 64'(dut.state_q), 64'(ST_HALTED));
        bus.halt = 1'b0;
        tick();
        bus.start = 1'b0;
        check("resume.state", 64'(dut.state_q), 64'(ST_RUN));
        tick();
        check_out("resume.1", 16'd1);
        tick();
        check_out("resume.2", 16'd2);
        check("resume.count", 64'(bus.fetch_count), 64'd10);

        // Reset mid-fetch while stalled.
        bus.out_ready = 1'b0;
        tick();
        check_out("prerst", 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        check("postrst.valid", 64'(bus.out_valid),    64'd0);
        check("postrst.addr",  64'(bus.inst_address), 64'd0);
        check("postrst.state", 64'(dut.state_q),      64'(ST_IDLE));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check_out("restart", 16'd0);

        // Out-of-range redirect sets a sticky fault.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0100;
        tick();
        bus.redirect_valid = 1'b0;
        check("fault.flag",  64'(bus.fault),        64'd1);
        check("fault.state", 64'(dut.state_q),      64'(ST_HALTED));
        check("fault.valid", 64'(bus.out_valid),    64'd0);
        check("fault.addr",  64'(bus.inst_address), 64'd1);
        check("fault.count", 64'(bus.fetch_count),  64'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("fault.sticky", 64'(bus.fault), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("fault.rst", 64'(bus.fault), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, width of the instruction word address.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter MEM_DEPTH, default 256, number of valid instruction words; the PC wraps within this range.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; leaves IDLE or HALTED and begins fetching.
REQ-007 halt  input  1  level; stops fetching after the currently held output is accepted.
REQ-008 inst_address  output  ADDR_W  word address to instruction memory; equals pc.
REQ-009 read_data  input  DATA_W  instruction word returned combinationally for inst_address.
REQ-010 redirect_valid  input  1  branch or jump request, sampled each cycle.
REQ-011 redirect_pc  input  ADDR_W  branch or jump target word address.
REQ-012 out_valid  output  1  out_inst and out_pc hold a fetched instruction.
REQ-013 out_ready  input  1  downstream decoder accepts the instruction when out_valid and out_ready are both high.
REQ-014 out_inst  output  DATA_W  registered instruction word.
REQ-015 out_pc  output  ADDR_W  address out_inst was fetched from.
REQ-016 fault  output  1  sticky flag: a redirect target was at or beyond MEM_DEPTH.
REQ-017 fetch_count  output  16  count of accepted instructions; saturates at 16'hFFFF.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and HALTED, encoded as a 2-bit state.
REQ-019 IDLE->RUN and HALTED->RUN on start; RUN->HALTED when halt is high and (out_valid is low, or out_valid and out_ready are both high); any state->HALTED when fault sets.
REQ-020 A load slot SHALL be defined as: RUN and (out_valid is low, or out_ready is high).
REQ-021 In a load slot without redirect: out_inst<=read_data, out_pc<=pc, out_valid<=1, and pc<=pc+1, with pc wrapping from MEM_DEPTH-1 to 0.
REQ-022 Latency SHALL be one cycle: the instruction at pc appears on out_inst the cycle after its load slot.
REQ-023 With out_valid high and out_ready low, out_inst, out_pc, out_valid and pc SHALL hold.
REQ-024 A redirect with redirect_pc below MEM_DEPTH SHALL take priority over all other actions: pc<=redirect_pc and out_valid<=0 (flush), in any state other than IDLE.
REQ-025 A redirect with redirect_pc at or above MEM_DEPTH SHALL set fault, clear out_valid and force HALTED, leaving pc unchanged.
REQ-026 If redirect and a handshake occur in the same cycle, the handshake SHALL count in fetch_count and the flush SHALL still occur.
REQ-027 If start and halt are both high, halt SHALL win and the state SHALL stay or become HALTED.
REQ-028 In HALTED, pc SHALL hold; start SHALL resume fetching from pc.
REQ-029 fetch_count SHALL increment on each handshake and stop at 16'hFFFF.
REQ-030 fault SHALL clear only on reset.

Reset
REQ-031 While rst_n is low: state=IDLE, pc=0, out_valid=0, out_inst=0, out_pc=0, fault=0, fetch_count=0, asynchronously.
REQ-032 Reset asserted mid-fetch SHALL drop any held instruction without a handshake.
REQ-033 After reset is released, no fetch SHALL occur until start is seen.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the ADDR_W, DATA_W and MEM_DEPTH defaults, and the reset PC constant 0.
REQ-035 The block SHALL be a single module with one natural sub-module, fetch_out_reg, holding the valid/data output register with its load, hold and flush controls.
REQ-036 The block SHALL contain no memory array; it drives inst_address directly into the existing instruction memory.

Verification
REQ-037 Memory word 0=32'h2000_0004, reset, start, out_ready=1 -> first out_valid two cycles after start, with out_pc=0 and out_inst=32'h2000_0004, then out_pc=1,2,3 on consecutive cycles.
REQ-038 out_ready=0 for 3 cycles while out_pc=2 -> out_inst, out_pc and inst_address stable; after release, the next out_pc=3 with no word skipped or duplicated.
REQ-039 Redirect to 16'h0005 while out_pc=3 -> one flushed cycle with out_valid=0, then out_pc=5.
REQ-040 Redirect to 16'h0100 with MEM_DEPTH=256 -> fault=1, state HALTED, out_valid=0, and fault held until rst_n.
REQ-041 Run pc to 255 -> next out_pc=0; halt asserted, then start -> fetching resumes from the held pc, with fetch_count equal to the number of handshakes.
REQ-042 rst_n pulsed low while out_valid=1 and out_ready=0 -> all outputs zero immediately and IDLE until start.
